// File: rtl/vc_flit_tx_if.sv
// vc_flit_tx_if: request, payload and flit-link signals of the VC packetizer.
// The slave modport is the packetizer side, and the master modport is the traffic source and link sink.
interface vc_flit_tx_if #(
    parameter int VC_W  = 2,
    parameter int LEN_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [VC_W-1:0]  req_vc;
    logic [3:0]       req_dx;
    logic [3:0]       req_dy;
    logic [LEN_W-1:0] req_len;
    logic [13:0]      req_tag;
    logic             wd_valid;
    logic             wd_ready;
    logic [31:0]      wd_data;
    logic [33:0]      fdata;
    logic             valid;
    logic             ready;
    logic [VC_W-1:0]  vc_id;
    logic             err;
    logic             busy;

    modport master (
        output req_valid, req_vc, req_dx, req_dy, req_len, req_tag, wd_valid, wd_data, ready,
        input  req_ready, wd_ready, fdata, valid, vc_id, err, busy
    );

    modport slave (
        input  req_valid, req_vc, req_dx, req_dy, req_len, req_tag, wd_valid, wd_data, ready,
        output req_ready, wd_ready, fdata, valid, vc_id, err, busy
    );
endinterface

// File: rtl/vc_flit_tx.sv
// vc_flit_tx: turns a packet request plus payload words into head/body/tail flits
// on a registered valid/ready link. A request with a zero destination is dropped and flagged on err.
module vc_flit_tx #(
    parameter int LEN_W = 8
) (
    input logic         clk,
    input logic         arst,
    vc_flit_tx_if.slave bus
);
    typedef enum logic {IDLE, DATA} state_t;

    state_t           state;
    logic [LEN_W-1:0] rem;
    logic             adv;
    logic             req_acc;
    logic             wd_acc;
    logic             last;

    // The output register may reload whenever it is empty or being drained this cycle
    assign adv           = !bus.valid | bus.ready;
    assign bus.req_ready = (state == IDLE) & adv;
    assign bus.wd_ready  = (state == DATA) & adv;
    assign bus.busy      = (state != IDLE) | bus.valid;
    assign req_acc       = bus.req_valid & bus.req_ready;
    assign wd_acc        = bus.wd_valid & bus.wd_ready;
    assign last          = rem == LEN_W'(1);

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state     <= IDLE;
            rem       <= '0;
            bus.valid <= 1'b0;
            bus.fdata <= '0;
            bus.vc_id <= '0;
            bus.err   <= 1'b0;
        end else begin
            bus.err <= 1'b0;
            if (adv)
                bus.valid <= 1'b0;
            if (req_acc) begin
                rem <= bus.req_len;
                if (|{bus.req_dx, bus.req_dy}) begin
                    bus.valid <= 1'b1;
                    bus.vc_id <= bus.req_vc;
                    bus.fdata <= {(bus.req_len == '0) ? 2'b10 : 2'b00, 2'b00, bus.req_dx, bus.req_dy,
                                  8'(bus.req_len), bus.req_tag};
                    state     <= (bus.req_len != '0) ? DATA : IDLE;
                end else begin
                    bus.err <= 1'b1;
                end
            end
            if (wd_acc) begin
                bus.valid <= 1'b1;
                bus.fdata <= {last ? 2'b11 : 2'b01, bus.wd_data};
                rem       <= rem - LEN_W'(1);
                state     <= last ? IDLE : DATA;
            end
        end
    end
endmodule

// File: tb/tb_vc_flit_tx.sv
// tb_vc_flit_tx: directed and randomized checks of vc_flit_tx against a transaction-level
// model that holds the flits still owed to the link, the payload words still expected and the error pulse that is due.
module tb_vc_flit_tx;
    logic clk = 1'b0;
    logic arst = 1'b0;
    always #5 clk = ~clk;

    vc_flit_tx_if bus ();
    vc_flit_tx dut (.clk(clk), .arst(arst), .bus(bus));

    typedef struct {
        logic [1:0]  vc;
        logic [3:0]  dx;
        logic [3:0]  dy;
        logic [7:0]  len;
        logic [13:0] tag;
    } req_t;

    req_t        req_q[$];
    logic [35:0] exp_q[$];
    int          rdy_pat[$];
    int          words_left = 0;
    logic [1:0]  cur_vc = '0;
    bit          exp_err = 0;
    int          vectors = 0;
    int          errs = 0;
    int          cycles = 0;
    int          rdy_pct = 100;
    int          wd_pct = 100;
    int          req_pct = 100;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [35:0] head_flit(input req_t r);
        return {r.vc, (r.len == 0) ? 2'b10 : 2'b00, 2'b00, r.dx, r.dy, r.len, r.tag};
    endfunction

    // One clock: drive at the falling edge, check the handshake-side outputs, then update the model across the rising edge
    task automatic step();
        bit          hs, racc, wacc, stall;
        logic [35:0] snap;
        logic [31:0] wdata;
        req_t        r;
        bus.req_valid = req_q.size() > 0 && $urandom_range(99) < req_pct;
        if (req_q.size() > 0) begin
            bus.req_vc  = req_q[0].vc;
            bus.req_dx  = req_q[0].dx;
            bus.req_dy  = req_q[0].dy;
            bus.req_len = req_q[0].len;
            bus.req_tag = req_q[0].tag;
        end
        bus.wd_valid = words_left > 0 ? $urandom_range(99) < wd_pct : $urandom_range(99) < 10;
        bus.wd_data  = $urandom;
        bus.ready    = rdy_pat.size() > 0 ? rdy_pat.pop_front() != 0 : $urandom_range(99) < rdy_pct;
        #1;
        chk("req_ready", bus.req_ready, words_left == 0 && (!bus.valid || bus.ready));
        chk("wd_ready", bus.wd_ready, words_left > 0 && (!bus.valid || bus.ready));
        hs    = bus.valid && bus.ready;
        racc  = bus.req_valid && bus.req_ready;
        wacc  = bus.wd_valid && bus.wd_ready;
        stall = bus.valid && !bus.ready;
        snap  = {bus.vc_id, bus.fdata};
        wdata = bus.wd_data;
        @(posedge clk);
        cycles++;
        if (hs && exp_q.size() > 0)
            void'(exp_q.pop_front());
        exp_err = 0;
        if (racc) begin
            r = req_q.pop_front();
            if (r.dx != 0 || r.dy != 0) begin
                exp_q.push_back(head_flit(r));
                words_left = r.len;
                cur_vc     = r.vc;
            end else begin
                exp_err = 1;
            end
        end
        if (wacc) begin
            words_left--;
            exp_q.push_back({cur_vc, words_left == 0 ? 2'b11 : 2'b01, wdata});
        end
        @(negedge clk);
        chk("valid", bus.valid, exp_q.size() != 0);
        if (exp_q.size() != 0)
            chk("flit", {bus.vc_id, bus.fdata}, exp_q[0]);
        chk("err", bus.err, exp_err);
        chk("busy", bus.busy, exp_q.size() != 0 || words_left > 0);
        if (stall)
            chk("stall_hold", {bus.vc_id, bus.fdata}, snap);
    endtask

    task automatic run_idle(input int maxc);
        int n = 0;
        while ((req_q.size() > 0 || words_left > 0 || exp_q.size() > 0) && n < maxc) begin
            step();
            n++;
        end
        chk("drain_timeout", n < maxc, 1);
    endtask

    initial begin
        req_t r;
        int   n;
        bus.req_valid = 0; bus.req_vc = '0; bus.req_dx = '0; bus.req_dy = '0;
        bus.req_len = '0; bus.req_tag = '0; bus.wd_valid = 0; bus.wd_data = '0; bus.ready = 0;
        @(negedge clk);
        chk("rst_valid", bus.valid, 0);
        chk("rst_fdata", bus.fdata, 0);
        chk("rst_vc", bus.vc_id, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_busy", bus.busy, 0);
        arst = 1'b1;

        // Head-only packet
        req_q.push_back('{2'd1, 4'd1, 4'd2, 8'd0, 14'd5});
        step();
        chk("t1_flit", {bus.vc_id, bus.fdata}, {2'd1, 34'h2_0480_0005});
        run_idle(50);

        // Full-rate three-word packet: accept, head, A, B, C
        cycles = 0;
        req_q.push_back('{2'd0, 4'd3, 4'd4, 8'd3, 14'h1234});
        run_idle(50);
        chk("t2_cycles", cycles, 5);

        // Same packet with the link stalled for three cycles on body A
        cycles = 0;
        rdy_pat = '{1, 1, 0, 0, 0};
        req_q.push_back('{2'd0, 4'd3, 4'd4, 8'd3, 14'h1234});
        run_idle(50);
        chk("t3_cycles", cycles, 8);

        // Zero destination is dropped with an error pulse
        req_q.push_back('{2'd2, 4'd0, 4'd0, 8'd3, 14'h3ff});
        step();
        chk("t4_err", bus.err, 1);
        chk("t4_valid", bus.valid, 0);
        step();
        chk("t4_err_clr", bus.err, 0);
        chk("t4_wd_ready", bus.wd_ready, 0);

        // Back-to-back packets on different VCs with no bubble
        cycles = 0;
        req_q.push_back('{2'd0, 4'd5, 4'd6, 8'd2, 14'h11});
        req_q.push_back('{2'd2, 4'd7, 4'd8, 8'd1, 14'h22});
        run_idle(50);
        chk("t5_cycles", cycles, 6);

        // Maximum length packet at full rate
        cycles = 0;
        req_q.push_back('{2'd3, 4'd15, 4'd15, 8'd255, 14'h3fff});
        run_idle(600);
        chk("max_cycles", cycles, 257);

        // Randomized traffic, backpressure and payload gaps
        rdy_pct = 70; wd_pct = 80; req_pct = 60;
        for (int i = 0; i < 60; i++) begin
            r.vc  = 2'($urandom);
            r.dx  = $urandom_range(7) == 0 ? 4'd0 : 4'($urandom);
            r.dy  = $urandom_range(7) == 0 ? 4'd0 : 4'($urandom);
            r.len = i == 30 ? 8'd255 : 8'($urandom_range(6));
            r.tag = 14'($urandom);
            req_q.push_back(r);
        end
        run_idle(20000);

        // Asynchronous reset in the middle of a packet
        rdy_pct = 100; wd_pct = 100; req_pct = 100;
        req_q.push_back('{2'd3, 4'd2, 4'd9, 8'd5, 14'h77});
        n = 0;
        while (words_left != 3 && n < 20) begin
            step();
            n++;
        end
        chk("t6_reach", words_left, 3);
        #2 arst = 1'b0;
        #1;
        chk("t6_valid", bus.valid, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_fdata", bus.fdata, 0);
        chk("t6_vc", bus.vc_id, 0);
        exp_q.delete();
        req_q.delete();
        words_left = 0;
        @(negedge clk);
        bus.req_valid = 0;
        bus.wd_valid  = 0;
        arst = 1'b1;
        #1;
        chk("t6_req_ready", bus.req_ready, 1);
        cycles = 0;
        req_q.push_back('{2'd1, 4'd4, 4'd1, 8'd2, 14'h2aa});
        run_idle(50);
        chk("t6_cycles", cycles, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
